// File: rtl/vga_pkg.sv
// ============================================================================
// Module : vga_pkg
// Brief  : Shared VGA timing constants, frame-buffer geometry and pixel fields.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_pkg;

    localparam int c_H_ACT  = 640;
    localparam int c_H_FP   = 16;
    localparam int c_H_SYNC = 96;
    localparam int c_H_BP   = 48;
    localparam int c_V_ACT  = 480;
    localparam int c_V_FP   = 10;
    localparam int c_V_SYNC = 2;
    localparam int c_V_BP   = 33;

    localparam int c_H_TOT = c_H_ACT + c_H_FP + c_H_SYNC + c_H_BP;
    localparam int c_V_TOT = c_V_ACT + c_V_FP + c_V_SYNC + c_V_BP;

    localparam int c_FB_W     = 640;
    localparam int c_FB_H     = 480;
    localparam int c_FB_DEPTH = c_FB_W * c_FB_H;
    localparam int c_ADDR_W   = 19;
    localparam int c_PIX_W    = 9;

    // Pixel layout {R[2:0],G[2:0],B[2:0]}, shared with the placement engine
    localparam int c_R_MSB = 8;
    localparam int c_R_LSB = 6;
    localparam int c_G_MSB = 5;
    localparam int c_G_LSB = 3;
    localparam int c_B_MSB = 2;
    localparam int c_B_LSB = 0;

    typedef struct packed {
        logic active;
        logic hsync_n;
        logic vsync_n;
        logic vblank;
        logic fstart;
    } ctl_t;

    localparam ctl_t c_CTL_IDLE = '{active: 1'b0, hsync_n: 1'b1, vsync_n: 1'b1,
                                    vblank: 1'b0, fstart: 1'b0};

    function automatic logic [7:0] expand3(input logic [2:0] c);
        return {c, c, c[2:1]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_scan_out_if.sv
// ============================================================================
// Module : vga_scan_out_if
// Brief  : videoMem read port plus DAC/connector video signals.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vga_scan_out_if;
    import vga_pkg::*;

    logic [c_ADDR_W-1:0] raddr;
    logic [c_PIX_W-1:0]  rdata;
    logic [7:0]          VGA_R;
    logic [7:0]          VGA_G;
    logic [7:0]          VGA_B;
    logic                hsync_n;
    logic                vsync_n;
    logic                blank_n;
    logic                vblank;
    logic                frame_start;

    modport master (
        output raddr,
        input  rdata,
        output VGA_R, VGA_G, VGA_B,
        output hsync_n, vsync_n, blank_n, vblank, frame_start
    );

    modport slave (
        input  raddr,
        output rdata,
        input  VGA_R, VGA_G, VGA_B,
        input  hsync_n, vsync_n, blank_n, vblank, frame_start
    );

endinterface

`default_nettype wire

// File: rtl/vga_timing.sv
// ============================================================================
// Module : vga_timing
// Brief  : Horizontal/vertical raster counters and raw timing flags.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACT  = c_H_ACT,
    parameter int H_FP   = c_H_FP,
    parameter int H_SYNC = c_H_SYNC,
    parameter int H_BP   = c_H_BP,
    parameter int V_ACT  = c_V_ACT,
    parameter int V_FP   = c_V_FP,
    parameter int V_SYNC = c_V_SYNC,
    parameter int V_BP   = c_V_BP
) (
    input  logic clk,
    input  logic rst_n,
    output ctl_t o_ctl,
    output logic o_frame_wrap
);

    localparam int c_HTOT = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int c_VTOT = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int c_HW   = $clog2(c_HTOT);
    localparam int c_VW   = $clog2(c_VTOT);

    localparam logic [c_HW-1:0] c_H_LAST = c_HW'(c_HTOT - 1);
    localparam logic [c_HW-1:0] c_H_VIS  = c_HW'(H_ACT);
    localparam logic [c_HW-1:0] c_HS_BEG = c_HW'(H_ACT + H_FP);
    localparam logic [c_HW-1:0] c_HS_END = c_HW'(H_ACT + H_FP + H_SYNC);
    localparam logic [c_VW-1:0] c_V_LAST = c_VW'(c_VTOT - 1);
    localparam logic [c_VW-1:0] c_V_VIS  = c_VW'(V_ACT);
    localparam logic [c_VW-1:0] c_VS_BEG = c_VW'(V_ACT + V_FP);
    localparam logic [c_VW-1:0] c_VS_END = c_VW'(V_ACT + V_FP + V_SYNC);

    logic [c_HW-1:0] r_hcnt;
    logic [c_VW-1:0] r_vcnt;
    logic            w_h_last;
    logic            w_v_last;

    assign w_h_last = (r_hcnt == c_H_LAST);
    assign w_v_last = (r_vcnt == c_V_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (w_h_last) begin
            r_hcnt <= '0;
            r_vcnt <= w_v_last ? '0 : r_vcnt + 1'b1;
        end else begin
            r_hcnt <= r_hcnt + 1'b1;
        end
    end

    always_comb begin
        o_ctl         = c_CTL_IDLE;
        o_ctl.active  = (r_hcnt < c_H_VIS) && (r_vcnt < c_V_VIS);
        o_ctl.hsync_n = !((r_hcnt >= c_HS_BEG) && (r_hcnt < c_HS_END));
        o_ctl.vsync_n = !((r_vcnt >= c_VS_BEG) && (r_vcnt < c_VS_END));
        o_ctl.vblank  = (r_vcnt >= c_V_VIS);
        o_ctl.fstart  = (r_hcnt == '0) && (r_vcnt == '0);
    end

    assign o_frame_wrap = w_h_last && w_v_last;

endmodule

`default_nettype wire

// File: rtl/vga_scan_out.sv
// ============================================================================
// Module : vga_scan_out
// Brief  : Raster read of videoMem, sync/colour alignment and RGB expansion.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_scan_out
    import vga_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int H_ACT   = c_H_ACT,
    parameter int H_FP    = c_H_FP,
    parameter int H_SYNC  = c_H_SYNC,
    parameter int H_BP    = c_H_BP,
    parameter int V_ACT   = c_V_ACT,
    parameter int V_FP    = c_V_FP,
    parameter int V_SYNC  = c_V_SYNC,
    parameter int V_BP    = c_V_BP
) (
    input  logic           clk,
    input  logic           rst_n,
    vga_scan_out_if.master bus
);

    localparam int                  c_DEPTH     = H_ACT * V_ACT;
    localparam logic [c_ADDR_W-1:0] c_ADDR_LAST = c_ADDR_W'(c_DEPTH - 1);

    ctl_t                w_ctl_raw;
    logic                w_frame_wrap;
    logic [c_ADDR_W-1:0] r_raddr;
    ctl_t                r_pipe [MEM_LAT];
    ctl_t                r_ctl_out;
    logic [7:0]          r_red;
    logic [7:0]          r_grn;
    logic [7:0]          r_blu;

    vga_timing #(
        .H_ACT  (H_ACT),
        .H_FP   (H_FP),
        .H_SYNC (H_SYNC),
        .H_BP   (H_BP),
        .V_ACT  (V_ACT),
        .V_FP   (V_FP),
        .V_SYNC (V_SYNC),
        .V_BP   (V_BP)
    ) u_timing (
        .clk          (clk),
        .rst_n        (rst_n),
        .o_ctl        (w_ctl_raw),
        .o_frame_wrap (w_frame_wrap)
    );

    // Saturate on the last pixel so the address never leaves the buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_raddr <= '0;
        end else if (w_frame_wrap) begin
            r_raddr <= '0;
        end else if (w_ctl_raw.active && (r_raddr != c_ADDR_LAST)) begin
            r_raddr <= r_raddr + 1'b1;
        end
    end

    // MEM_LAT stages here plus the output register keep flags level with rdata
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_LAT; i++) begin
                r_pipe[i] <= c_CTL_IDLE;
            end
        end else begin
            r_pipe[0] <= w_ctl_raw;
            for (int i = 1; i < MEM_LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctl_out <= c_CTL_IDLE;
            r_red     <= '0;
            r_grn     <= '0;
            r_blu     <= '0;
        end else begin
            r_ctl_out <= r_pipe[MEM_LAT-1];
            if (r_pipe[MEM_LAT-1].active) begin
                r_red <= expand3(bus.rdata[c_R_MSB:c_R_LSB]);
                r_grn <= expand3(bus.rdata[c_G_MSB:c_G_LSB]);
                r_blu <= expand3(bus.rdata[c_B_MSB:c_B_LSB]);
            end else begin
                r_red <= '0;
                r_grn <= '0;
                r_blu <= '0;
            end
        end
    end

    assign bus.raddr       = r_raddr;
    assign bus.VGA_R       = r_red;
    assign bus.VGA_G       = r_grn;
    assign bus.VGA_B       = r_blu;
    assign bus.hsync_n     = r_ctl_out.hsync_n;
    assign bus.vsync_n     = r_ctl_out.vsync_n;
    assign bus.blank_n     = r_ctl_out.active;
    assign bus.vblank      = r_ctl_out.vblank;
    assign bus.frame_start = r_ctl_out.fstart;

endmodule

`default_nettype wire

// File: tb/tb_vga_scan_out.sv
// ============================================================================
// Module : tb_vga_scan_out
// Brief  : Bench for vga_scan_out: full-size and reduced-geometry instances.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_scan_out;

    localparam int S_HA = 20, S_HF = 4, S_HS = 6, S_HB = 4;
    localparam int S_VA = 8,  S_VF = 2, S_VS = 2, S_VB = 3;

    typedef struct packed {
        logic [18:0] raddr;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
        logic        hs_n;
        logic        vs_n;
        logic        bl_n;
        logic        vb;
        logic        fs;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    int         n = 0;
    int         mode = 0;
    logic [8:0] cval = 9'h000;
    int         phase = 0;
    int         tests = 0;
    int         fails = 0;
    int         cnt_fs = 0, cnt_vs = 0, cnt_hs = 0, cnt_blank = 0;

    vga_scan_out_if bus_full ();
    vga_scan_out_if bus_s1 ();
    vga_scan_out_if bus_s2 ();

    vga_scan_out #(.MEM_LAT(1)) u_full (.clk(clk), .rst_n(rst_n), .bus(bus_full));

    vga_scan_out #(.MEM_LAT(1), .H_ACT(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
                   .V_ACT(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB))
        u_s1 (.clk(clk), .rst_n(rst_n), .bus(bus_s1));

    vga_scan_out #(.MEM_LAT(2), .H_ACT(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
                   .V_ACT(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB))
        u_s2 (.clk(clk), .rst_n(rst_n), .bus(bus_s2));

    always #5 clk = ~clk;

    // Edges since reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n <= 0;
        else        n <= n + 1;
    end

    function automatic logic [8:0] pat(input int a);
        return (mode == 0) ? 9'(a % 512) : cval;
    endfunction

    // Memory models: one-cycle and two-cycle read latency
    logic [8:0] mem_full_q, mem_s1_q, mem_s2_a, mem_s2_b;
    always @(posedge clk) begin
        mem_full_q <= pat(int'(bus_full.raddr));
        mem_s1_q   <= pat(int'(bus_s1.raddr));
        mem_s2_a   <= pat(int'(bus_s2.raddr));
        mem_s2_b   <= mem_s2_a;
    end
    assign bus_full.rdata = mem_full_q;
    assign bus_s1.rdata   = mem_s1_q;
    assign bus_s2.rdata   = mem_s2_b;

    function automatic logic [7:0] ex(input int c);
        return 8'((c * 255 + 3) / 7);
    endfunction

    // Expected pins after k edges: raddr tracks the counter position, the
    // rest shows the pixel lat+1 positions earlier.
    function automatic obs_t model(input int lat, input int ha, input int hf, input int hs,
                                   input int hb, input int va, input int vf, input int vs,
                                   input int vb, input int k);
        int ht, vt, depth, p, x, y, a, q;
        logic [8:0] px;
        obs_t m;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        depth = ha * va;
        p = k % (ht * vt);
        x = p % ht;
        y = p / ht;
        if (y < va) a = y * ha + ((x < ha) ? x : ha);
        else        a = depth;
        if (a > depth - 1) a = depth - 1;
        m.raddr = 19'(a);
        m.r = 8'h00; m.g = 8'h00; m.b = 8'h00;
        m.hs_n = 1'b1; m.vs_n = 1'b1; m.bl_n = 1'b0; m.vb = 1'b0; m.fs = 1'b0;
        q = k - (lat + 1);
        if (q >= 0) begin
            p = q % (ht * vt);
            x = p % ht;
            y = p / ht;
            m.bl_n = (x < ha) && (y < va);
            m.hs_n = !((x >= ha + hf) && (x < ha + hf + hs));
            m.vs_n = !((y >= va + vf) && (y < va + vf + vs));
            m.vb   = (y >= va);
            m.fs   = (p == 0);
            if (m.bl_n) begin
                px  = pat(y * ha + x);
                m.r = ex(int'(px[8:6]));
                m.g = ex(int'(px[5:3]));
                m.b = ex(int'(px[2:0]));
            end
        end
        return m;
    endfunction

    function automatic obs_t mk(input logic [18:0] ra, input logic [7:0] r, input logic [7:0] g,
                                input logic [7:0] b, input logic hs, input logic vs,
                                input logic bl, input logic vbk, input logic fs);
        obs_t o;
        o.raddr = ra; o.r = r; o.g = g; o.b = b;
        o.hs_n = hs; o.vs_n = vs; o.bl_n = bl; o.vb = vbk; o.fs = fs;
        return o;
    endfunction

    task automatic cmp(input string nm, input obs_t a, input obs_t e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s n=%0d got raddr=%0d rgb=%h%h%h hs=%b vs=%b bl=%b vb=%b fs=%b want raddr=%0d rgb=%h%h%h hs=%b vs=%b bl=%b vb=%b fs=%b",
                     nm, n, a.raddr, a.r, a.g, a.b, a.hs_n, a.vs_n, a.bl_n, a.vb, a.fs,
                     e.raddr, e.r, e.g, e.b, e.hs_n, e.vs_n, e.bl_n, e.vb, e.fs);
        end
    endtask

    task automatic lit(input string nm, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s n=%0d got %0h want %0h", nm, n, a, e);
        end
    endtask

    // One clock: sample on the falling edge and compare every instance
    task automatic tick();
        @(negedge clk);
        cmp("full", mk(bus_full.raddr, bus_full.VGA_R, bus_full.VGA_G, bus_full.VGA_B,
                       bus_full.hsync_n, bus_full.vsync_n, bus_full.blank_n,
                       bus_full.vblank, bus_full.frame_start),
            model(1, 640, 16, 96, 48, 480, 10, 2, 33, n));
        cmp("s1", mk(bus_s1.raddr, bus_s1.VGA_R, bus_s1.VGA_G, bus_s1.VGA_B,
                     bus_s1.hsync_n, bus_s1.vsync_n, bus_s1.blank_n,
                     bus_s1.vblank, bus_s1.frame_start),
            model(1, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, n));
        cmp("s2", mk(bus_s2.raddr, bus_s2.VGA_R, bus_s2.VGA_G, bus_s2.VGA_B,
                     bus_s2.hsync_n, bus_s2.vsync_n, bus_s2.blank_n,
                     bus_s2.vblank, bus_s2.frame_start),
            model(2, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, n));
        if (phase == 1) begin
            if (n >= 1 && n <= 1530) begin
                if (bus_s1.frame_start) cnt_fs++;
                if (!bus_s1.vsync_n)    cnt_vs++;
            end
            if (n >= 2 && n <= 35 && !bus_s1.hsync_n) cnt_hs++;
            if (n >= 2 && n <= 801 && !bus_full.blank_n && bus_full.VGA_R == 8'h00 &&
                bus_full.VGA_G == 8'h00 && bus_full.VGA_B == 8'h00) cnt_blank++;
        end
    endtask

    task automatic wait_n(input int t);
        int g;
        g = 0;
        while (n < t && g < 5000) begin
            tick();
            g++;
        end
        if (n != t) begin
            tests++;
            fails++;
            $display("FAIL wait_n got n=%0d want %0d", n, t);
        end
    endtask

    task automatic reset_cycle();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        // Phase 1: address pattern rdata = addr[8:0]
        phase = 1;
        mode  = 0;
        rst_n = 1'b0;
        repeat (3) tick();
        lit("rst_raddr", 32'(bus_full.raddr), 32'd0);
        lit("rst_rgb", {8'h00, bus_full.VGA_R, bus_full.VGA_G, bus_full.VGA_B}, 32'd0);
        lit("rst_flags", {27'd0, bus_full.hsync_n, bus_full.vsync_n, bus_full.blank_n,
                          bus_full.vblank, bus_full.frame_start}, 32'b11000);
        rst_n = 1'b1;
        wait_n(1);
        lit("raddr_1", 32'(bus_full.raddr), 32'd1);
        lit("fs_n1", 32'(bus_s1.frame_start), 32'd0);
        wait_n(2);
        lit("fs_n2_full", 32'(bus_full.frame_start), 32'd1);
        lit("fs_n2_s1", 32'(bus_s1.frame_start), 32'd1);
        lit("fs_n2_s2", 32'(bus_s2.frame_start), 32'd0);
        lit("rgb_pix0", {8'h00, bus_full.VGA_R, bus_full.VGA_G, bus_full.VGA_B}, 32'd0);
        wait_n(3);
        lit("rgb_pix1", {8'h00, bus_full.VGA_R, bus_full.VGA_G, bus_full.VGA_B}, 32'h000024);
        lit("fs_n3_s2", 32'(bus_s2.frame_start), 32'd1);
        wait_n(257);
        lit("s1_raddr_last", 32'(bus_s1.raddr), 32'd159);
        wait_n(271);
        lit("s1_raddr_hold", 32'(bus_s1.raddr), 32'd159);
        wait_n(510);
        lit("s1_raddr_wrap", 32'(bus_s1.raddr), 32'd0);
        wait_n(639);
        lit("raddr_639", 32'(bus_full.raddr), 32'd639);
        wait_n(657);
        lit("hs_657", 32'(bus_full.hsync_n), 32'd1);
        wait_n(658);
        lit("hs_658", 32'(bus_full.hsync_n), 32'd0);
        wait_n(753);
        lit("hs_753", 32'(bus_full.hsync_n), 32'd0);
        wait_n(754);
        lit("hs_754", 32'(bus_full.hsync_n), 32'd1);
        wait_n(800);
        lit("raddr_640", 32'(bus_full.raddr), 32'd640);
        wait_n(801);
        lit("blank_count", 32'(cnt_blank), 32'd160);
        lit("s1_hs_count", 32'(cnt_hs), 32'd6);
        wait_n(1531);
        lit("s1_fs_count", 32'(cnt_fs), 32'd3);
        lit("s1_vs_count", 32'(cnt_vs), 32'd204);

        // Phase 2: constant colour, then a mid-frame reset
        phase = 2;
        mode  = 1;
        cval  = 9'b101_010_001;
        reset_cycle();
        wait_n(2);
        lit("rgb_151", {8'h00, bus_full.VGA_R, bus_full.VGA_G, bus_full.VGA_B}, 32'h00B64924);
        wait_n(22);
        lit("s1_blank_rgb", {8'h00, bus_s1.VGA_R, bus_s1.VGA_G, bus_s1.VGA_B}, 32'd0);
        lit("s1_blank_n", 32'(bus_s1.blank_n), 32'd0);
        wait_n(180);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        lit("mid_raddr_full", 32'(bus_full.raddr), 32'd0);
        lit("mid_raddr_s1", 32'(bus_s1.raddr), 32'd0);
        lit("mid_rgb", {8'h00, bus_full.VGA_R, bus_full.VGA_G, bus_full.VGA_B}, 32'd0);
        lit("mid_blank_n", 32'(bus_full.blank_n), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        wait_n(1);
        lit("restart_raddr", 32'(bus_s1.raddr), 32'd1);
        lit("restart_fs1", 32'(bus_s1.frame_start), 32'd0);
        wait_n(2);
        lit("restart_fs2", 32'(bus_s1.frame_start), 32'd1);
        wait_n(300);

        // Phase 3: full white
        phase = 3;
        cval  = 9'h1FF;
        reset_cycle();
        wait_n(2);
        lit("rgb_1ff", {8'h00, bus_full.VGA_R, bus_full.VGA_G, bus_full.VGA_B}, 32'h00FFFFFF);
        wait_n(40);
        lit("s1_rgb_1ff", {8'h00, bus_s1.VGA_R, bus_s1.VGA_G, bus_s1.VGA_B}, 32'h00FFFFFF);
        wait_n(600);

        // Phase 4: 0x088 is an ordinary colour
        phase = 4;
        cval  = 9'h088;
        reset_cycle();
        wait_n(5);
        lit("rgb_088", {8'h00, bus_full.VGA_R, bus_full.VGA_G, bus_full.VGA_B}, 32'h00492400);
        lit("s2_rgb_088", {8'h00, bus_s2.VGA_R, bus_s2.VGA_G, bus_s2.VGA_B}, 32'h00492400);
        wait_n(100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
